// File: rtl/io_interrupt_unit.sv
// I/O and interrupt stage: INPR/OUTR/FGI/FGO/IEN/R state, device handshakes,
// register-reference I/O decode and interrupt-cycle (RT0..RT2) strobes.
module io_interrupt_unit #(
  parameter int unsigned CHAR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [2:0]        s,
  input  logic              io_ex,
  input  logic [5:0]        ir_b,
  input  logic [CHAR_W-1:0] ac_low,
  input  logic [CHAR_W-1:0] dev_in_data,
  input  logic              dev_in_valid,
  output logic              dev_in_ready,
  output logic [CHAR_W-1:0] dev_out_data,
  output logic              dev_out_valid,
  input  logic              dev_out_ack,
  output logic [CHAR_W-1:0] inp_r,
  output logic              r,
  output logic              ien,
  output logic              fgi,
  output logic              fgo,
  output logic              ac_inp_ld,
  output logic              pc_inr,
  output logic              sc_clr,
  output logic              ar_clr,
  output logic              tr_ld,
  output logic              mem_write,
  output logic              pc_clr
);

  logic [CHAR_W-1:0] inpr_q, inpr_n, outr_q, outr_n;
  logic              fgi_q, fgi_n, fgo_q, fgo_n;
  logic              ien_q, ien_n, r_q, r_n;
  logic              io_dec;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inpr_q <= '0;
      outr_q <= '0;
      fgi_q  <= 1'b0;
      fgo_q  <= 1'b1;
      ien_q  <= 1'b0;
      r_q    <= 1'b0;
    end else begin
      inpr_q <= inpr_n;
      outr_q <= outr_n;
      fgi_q  <= fgi_n;
      fgo_q  <= fgo_n;
      ien_q  <= ien_n;
      r_q    <= r_n;
    end
  end

  // Next-state and strobe decode
  always_comb begin
    inpr_n    = inpr_q;
    outr_n    = outr_q;
    fgi_n     = fgi_q;
    fgo_n     = fgo_q;
    ien_n     = ien_q;
    r_n       = r_q;
    ac_inp_ld = 1'b0;
    pc_inr    = 1'b0;
    sc_clr    = 1'b0;
    ar_clr    = 1'b0;
    tr_ld     = 1'b0;
    mem_write = 1'b0;
    pc_clr    = 1'b0;
    io_dec    = io_ex && !r_q;

    // INP clears first so a same-edge capture into an empty INPR is not lost
    if (io_dec && ir_b[5]) fgi_n = 1'b0;
    if (dev_in_valid && !fgi_q) begin
      inpr_n = dev_in_data;
      fgi_n  = 1'b1;
    end

    // OUT overrides a coincident device ack
    if (dev_out_ack && !fgo_q) fgo_n = 1'b1;
    if (io_dec && ir_b[4]) begin
      outr_n = ac_low;
      fgo_n  = 1'b0;
    end

    if (io_dec && ir_b[1]) ien_n = 1'b1;
    if (io_dec && ir_b[0]) ien_n = 1'b0;

    if ((s >= 3'd3) && ien_q && (fgi_q || fgo_q) && !r_q) r_n = 1'b1;

    if (r_q) begin
      unique case (s)
        3'd0: begin
          ar_clr = 1'b1;
          tr_ld  = 1'b1;
        end
        3'd1: begin
          mem_write = 1'b1;
          pc_clr    = 1'b1;
        end
        3'd2: begin
          pc_inr = 1'b1;
          sc_clr = 1'b1;
          ien_n  = 1'b0;
          r_n    = 1'b0;
        end
        default: ;
      endcase
    end else if (io_ex) begin
      ac_inp_ld = ir_b[5];
      pc_inr    = (ir_b[3] && fgi_q) || (ir_b[2] && fgo_q);
      sc_clr    = 1'b1;
    end

    // Strobes are forced low for the whole reset window
    if (rst) begin
      ac_inp_ld = 1'b0;
      pc_inr    = 1'b0;
      sc_clr    = 1'b0;
      ar_clr    = 1'b0;
      tr_ld     = 1'b0;
      mem_write = 1'b0;
      pc_clr    = 1'b0;
    end
  end

  assign inp_r         = inpr_q;
  assign dev_out_data  = outr_q;
  assign fgi           = fgi_q;
  assign fgo           = fgo_q;
  assign ien           = ien_q;
  assign r             = r_q;
  assign dev_in_ready  = ~fgi_q;
  assign dev_out_valid = ~fgo_q;

endmodule

// File: tb/tb_io_interrupt_unit.sv
// Self-checking bench for io_interrupt_unit: vector table through a scoreboard
// queue, plus hand-written reset sequences.
module tb_io_interrupt_unit;

  localparam int unsigned CHAR_W = 8;

  localparam logic [6:0] ST_INP = 7'b1000000;
  localparam logic [6:0] ST_INR = 7'b0100000;
  localparam logic [6:0] ST_SC  = 7'b0010000;
  localparam logic [6:0] ST_AR  = 7'b0001000;
  localparam logic [6:0] ST_TR  = 7'b0000100;
  localparam logic [6:0] ST_MW  = 7'b0000010;
  localparam logic [6:0] ST_PCC = 7'b0000001;

  typedef struct {
    logic [2:0]  s;
    logic        io_ex;
    logic [5:0]  ir_b;
    logic [7:0]  ac;
    logic [7:0]  din;
    logic        dinv;
    logic        ack;
    logic [6:0]  strb;
    logic [7:0]  inpr;
    logic [7:0]  outr;
    logic        fgi;
    logic        fgo;
    logic        ien;
    logic        r;
  } vec_t;

  logic              clk = 1'b0;
  logic              rst;
  logic [2:0]        s;
  logic              io_ex;
  logic [5:0]        ir_b;
  logic [CHAR_W-1:0] ac_low, dev_in_data, dev_out_data, inp_r;
  logic              dev_in_valid, dev_in_ready, dev_out_valid, dev_out_ack;
  logic              r, ien, fgi, fgo;
  logic              ac_inp_ld, pc_inr, sc_clr, ar_clr, tr_ld, mem_write, pc_clr;

  int n_checks = 0;
  int n_fail   = 0;

  vec_t vecs[23];
  vec_t exp_q[$];

  always #5 clk = ~clk;

  io_interrupt_unit #(.CHAR_W(CHAR_W)) dut (
    .clk(clk), .rst(rst), .s(s), .io_ex(io_ex), .ir_b(ir_b), .ac_low(ac_low),
    .dev_in_data(dev_in_data), .dev_in_valid(dev_in_valid), .dev_in_ready(dev_in_ready),
    .dev_out_data(dev_out_data), .dev_out_valid(dev_out_valid), .dev_out_ack(dev_out_ack),
    .inp_r(inp_r), .r(r), .ien(ien), .fgi(fgi), .fgo(fgo),
    .ac_inp_ld(ac_inp_ld), .pc_inr(pc_inr), .sc_clr(sc_clr), .ar_clr(ar_clr),
    .tr_ld(tr_ld), .mem_write(mem_write), .pc_clr(pc_clr)
  );

  function automatic logic [6:0] strobes();
    return {ac_inp_ld, pc_inr, sc_clr, ar_clr, tr_ld, mem_write, pc_clr};
  endfunction

  // {inpr, outr, fgi, fgo, ien, r, dev_in_ready, dev_out_valid}
  function automatic logic [21:0] dut_state();
    return {inp_r, dev_out_data, fgi, fgo, ien, r, dev_in_ready, dev_out_valid};
  endfunction

  function automatic logic [21:0] exp_state(input vec_t v);
    return {v.inpr, v.outr, v.fgi, v.fgo, v.ien, v.r, ~v.fgi, ~v.fgo};
  endfunction

  function automatic vec_t mk(input logic [2:0] s_i, input logic ex, input logic [5:0] b,
                              input logic [7:0] ac, input logic [7:0] din, input logic dv,
                              input logic ak, input logic [6:0] st, input logic [7:0] ip,
                              input logic [7:0] op, input logic fi, input logic fo,
                              input logic ie, input logic rr);
    vec_t v;
    v.s = s_i; v.io_ex = ex; v.ir_b = b; v.ac = ac; v.din = din; v.dinv = dv; v.ack = ak;
    v.strb = st; v.inpr = ip; v.outr = op; v.fgi = fi; v.fgo = fo; v.ien = ie; v.r = rr;
    return v;
  endfunction

  task automatic check7(input string name, input logic [6:0] act, input logic [6:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", name, act, req);
    end
  endtask

  task automatic check22(input string name, input logic [21:0] act, input logic [21:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, req);
    end
  endtask

  // Drive one vector, sample strobes mid-cycle, then check registered state after the edge
  task automatic apply(input int idx);
    vec_t v, e;
    logic [6:0] st;
    v = vecs[idx];
    s = v.s; io_ex = v.io_ex; ir_b = v.ir_b; ac_low = v.ac;
    dev_in_data = v.din; dev_in_valid = v.dinv; dev_out_ack = v.ack;
    exp_q.push_back(v);
    @(negedge clk);
    st = strobes();
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check7($sformatf("vec%0d strobes", idx), st, e.strb);
    check22($sformatf("vec%0d state", idx), dut_state(), exp_state(e));
  endtask

  initial begin
    //        s     ex    ir_b       ac     din    dv    ak    strobes          inpr   outr   fgi   fgo   ien   r
    vecs[0]  = mk(3'd0, 1'b0, 6'b000000, 8'h00, 8'h41, 1'b1, 1'b0, 7'b0,            8'h41, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    vecs[1]  = mk(3'd0, 1'b0, 6'b000000, 8'h00, 8'h42, 1'b1, 1'b0, 7'b0,            8'h41, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    vecs[2]  = mk(3'd3, 1'b1, 6'b100000, 8'h00, 8'h42, 1'b1, 1'b0, ST_INP | ST_SC,  8'h41, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
    vecs[3]  = mk(3'd0, 1'b0, 6'b000000, 8'h00, 8'h42, 1'b1, 1'b0, 7'b0,            8'h42, 8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    vecs[4]  = mk(3'd3, 1'b1, 6'b010000, 8'h5A, 8'h00, 1'b0, 1'b0, ST_SC,           8'h42, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
    vecs[5]  = mk(3'd3, 1'b1, 6'b000100, 8'h00, 8'h00, 1'b0, 1'b0, ST_SC,           8'h42, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b0);
    vecs[6]  = mk(3'd0, 1'b0, 6'b000000, 8'h00, 8'h00, 1'b0, 1'b1, 7'b0,            8'h42, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b0);
    vecs[7]  = mk(3'd3, 1'b1, 6'b000100, 8'h00, 8'h00, 1'b0, 1'b0, ST_INR | ST_SC,  8'h42, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b0);
    vecs[8]  = mk(3'd3, 1'b1, 6'b001000, 8'h00, 8'h00, 1'b0, 1'b0, ST_INR | ST_SC,  8'h42, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b0);
    vecs[9]  = mk(3'd3, 1'b1, 6'b001100, 8'h00, 8'h00, 1'b0, 1'b0, ST_INR | ST_SC,  8'h42, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b0);
    vecs[10] = mk(3'd3, 1'b1, 6'b000010, 8'h00, 8'h00, 1'b0, 1'b0, ST_SC,           8'h42, 8'h5A, 1'b1, 1'b1, 1'b1, 1'b0);
    vecs[11] = mk(3'd4, 1'b0, 6'b000000, 8'h00, 8'h00, 1'b0, 1'b0, 7'b0,            8'h42, 8'h5A, 1'b1, 1'b1, 1'b1, 1'b1);
    vecs[12] = mk(3'd0, 1'b0, 6'b000000, 8'h00, 8'h00, 1'b0, 1'b0, ST_AR | ST_TR,   8'h42, 8'h5A, 1'b1, 1'b1, 1'b1, 1'b1);
    vecs[13] = mk(3'd1, 1'b0, 6'b000000, 8'h00, 8'h00, 1'b0, 1'b0, ST_MW | ST_PCC,  8'h42, 8'h5A, 1'b1, 1'b1, 1'b1, 1'b1);
    vecs[14] = mk(3'd2, 1'b0, 6'b000000, 8'h00, 8'h00, 1'b0, 1'b0, ST_INR | ST_SC,  8'h42, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b0);
    vecs[15] = mk(3'd0, 1'b0, 6'b000000, 8'h00, 8'h00, 1'b0, 1'b0, 7'b0,            8'h42, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b0);
    vecs[16] = mk(3'd3, 1'b1, 6'b000011, 8'h00, 8'h00, 1'b0, 1'b0, ST_SC,           8'h42, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b0);
    vecs[17] = mk(3'd3, 1'b1, 6'b010000, 8'hA5, 8'h00, 1'b0, 1'b1, ST_SC,           8'h42, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    vecs[18] = mk(3'd0, 1'b0, 6'b000000, 8'h00, 8'h00, 1'b0, 1'b1, 7'b0,            8'h42, 8'hA5, 1'b1, 1'b1, 1'b0, 1'b0);
    vecs[19] = mk(3'd3, 1'b1, 6'b000010, 8'h00, 8'h00, 1'b0, 1'b0, ST_SC,           8'h42, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b0);
    vecs[20] = mk(3'd5, 1'b0, 6'b000000, 8'h00, 8'h00, 1'b0, 1'b0, 7'b0,            8'h42, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b1);
    vecs[21] = mk(3'd0, 1'b1, 6'b100000, 8'h00, 8'h00, 1'b0, 1'b0, ST_AR | ST_TR,   8'h42, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b1);
    vecs[22] = mk(3'd1, 1'b0, 6'b000000, 8'h00, 8'h00, 1'b0, 1'b0, ST_MW | ST_PCC,  8'h42, 8'hA5, 1'b1, 1'b1, 1'b1, 1'b1);

    // Reset with an I/O execute pending: strobes must stay low
    rst = 1'b1; s = 3'd3; io_ex = 1'b1; ir_b = 6'b111111; ac_low = 8'hFF;
    dev_in_data = 8'h00; dev_in_valid = 1'b0; dev_out_ack = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check7("reset strobes", strobes(), 7'b0);
    check22("reset state", dut_state(), {8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
    io_ex = 1'b0; ir_b = 6'b000000; s = 3'd0; ac_low = 8'h00;
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    check22("post-reset state", dut_state(), {8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});

    for (int i = 0; i < 23; i++) apply(i);

    // Still in RT1 here; async reset must kill strobes and R at once
    check7("rt1 before reset", strobes(), ST_MW | ST_PCC);
    rst = 1'b1;
    #1;
    check7("rt1 reset strobes", strobes(), 7'b0);
    check22("rt1 reset state", dut_state(), {8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});
    @(posedge clk);
    #1 rst = 1'b0;
    s = 3'd4;
    @(posedge clk);
    #1;
    check22("no R after reset", dut_state(), {8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/io_interrupt_unit.md
# io_interrupt_unit

Input/output and interrupt stage for the basic-computer datapath. It sits directly upstream of the fetch circuit and supplies it with `inp_r` (8-bit input character) and `r` (interrupt-cycle flip-flop). It owns the INPR/OUTR/FGI/FGO/IEN/R state and performs the two device handshakes. It also decodes the register-reference I/O instructions (INP, OUT, SKI, SKO, ION, IOF) and emits the interrupt-cycle control strobes (RT0–RT2) for the datapath.

## Interface
Parameters:
- `CHAR_W`, default 8: width of INPR/OUTR and of the device data buses.

Ports (clock and reset first):
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `s` in 3: sequence-counter value (T0..T7) from the control unit.
- `io_ex` in 1: asserted by the control unit during D7·I·T3, the I/O-instruction execute cycle.
- `ir_b` in 6: IR bits B11..B6, index 5 = B11.
- `ac_low` in CHAR_W: AC(7:0).
- `dev_in_data` in CHAR_W: character from the input device.
- `dev_in_valid` in 1: input device offers a character.
- `dev_in_ready` out 1: equals ~FGI.
- `dev_out_data` out CHAR_W: OUTR.
- `dev_out_valid` out 1: equals ~FGO.
- `dev_out_ack` in 1: output device has consumed OUTR.
- `inp_r` out CHAR_W: INPR.
- `r` out 1: interrupt-cycle flip-flop R.
- `ien` out 1: interrupt enable IEN.
- `fgi` out 1: input flag FGI.
- `fgo` out 1: output flag FGO.
- `ac_inp_ld` out 1: AC(7:0) ← INPR strobe.
- `pc_inr` out 1: PC increment, for skips and RT2.
- `sc_clr` out 1: sequence-counter clear.
- `ar_clr` out 1: AR ← 0 (RT0).
- `tr_ld` out 1: TR ← PC (RT0).
- `mem_write` out 1: M[AR] ← TR (RT1).
- `pc_clr` out 1: PC ← 0 (RT1).

## Operation
- Reset values: INPR=0, OUTR=0, FGI=0, FGO=1, IEN=0, R=0. All strobe outputs are 0 while `rst` is high.
- Input handshake: on an edge where `dev_in_valid` && FGI==0, INPR ← `dev_in_data` and FGI ← 1. Offers while FGI==1 are ignored; the device holds its data until it sees `dev_in_ready`.
- Output handshake: on an edge where `dev_out_ack` && FGO==0, FGO ← 1. An ack while FGO==1 is ignored. OUTR holds its value after the ack.
- I/O execute, combinational strobes qualified by `io_ex`, with register updates at the end of the cycle:
  - B11 INP: `ac_inp_ld`=1; FGI ← 0.
  - B10 OUT: OUTR ← `ac_low`; FGO ← 0.
  - B9 SKI: `pc_inr`=1 if FGI==1.
  - B8 SKO: `pc_inr`=1 if FGO==1.
  - B7 ION: IEN ← 1.
  - B6 IOF: IEN ← 0.
  - `sc_clr`=1 for every I/O execute cycle.
- Multiple B bits set at once: each bit is decoded independently. ION with IOF → IEN=0. SKI with SKO → a single `pc_inr`.
- R set: R ← 1 at the edge ending any cycle where `s`∉{0,1,2}, IEN==1, (FGI||FGO), and R==0.
- Interrupt cycle, when R==1:
  - s==0 (RT0): `ar_clr`=1, `tr_ld`=1.
  - s==1 (RT1): `mem_write`=1, `pc_clr`=1.
  - s==2 (RT2): `pc_inr`=1, `sc_clr`=1; IEN ← 0 and R ← 0 at the edge.
- The interrupt-cycle strobes replace fetch. `io_ex` is never asserted while R==1; if it is, the interrupt strobes take priority and the I/O decode is suppressed.

## Timing
- Flags, INPR, OUTR, IEN and R are registered. All strobes are combinational from the current `s`, `io_ex`, `ir_b`, flags and R, valid within the same cycle.
- Device handshake latency: `dev_in_ready` falls one cycle after an accepted offer. `dev_out_valid` rises one cycle after the OUT execute cycle.
- INP clearing FGI in the same cycle as `dev_in_valid`: no capture that cycle, because `dev_in_ready` was 0. Capture happens on the next edge if the offer is still held.
- OUT in the same cycle as `dev_out_ack`: OUT wins. FGO=0 afterwards and OUTR holds the new value.
- The skip decision uses the flag value before that cycle's edge.
- R set uses the registered IEN, so ION at T3 can raise R at the earliest on the next cycle with `s`≥3. The cycle after RT2 is `s`==0 with R==0, so the ISR fetch proceeds normally.
- Reset asserted mid-interrupt-cycle: the strobes drop immediately, and R=0 and IEN=0 asynchronously.

## Test plan
- Reset, then release → `inp_r`=0, FGI=0, FGO=1, IEN=0, R=0, `dev_in_ready`=1, `dev_out_valid`=0.
- `dev_in_data`=0x41 with valid for 1 cycle → FGI=1, `inp_r`=0x41. A second offer of 0x42 is ignored. INP execute → `ac_inp_ld`=1 that cycle, FGI=0 next cycle, then 0x42 is captured.
- `ac_low`=0x5A with OUT execute → `dev_out_data`=0x5A, `dev_out_valid`=1. SKO → `pc_inr`=0. `dev_out_ack` → FGO=1. SKO → `pc_inr`=1.
- ION, then hold `s`=4 with FGI=1 → R=1 after one edge. Step `s`=0,1,2 → see `ar_clr`/`tr_ld`, then `mem_write`/`pc_clr`, then `pc_inr`/`sc_clr`. Afterwards R=0 and IEN=0.
- ir_b with B7 and B6 both set under `io_ex` → IEN=0. Assert `rst` during RT1 → all strobes 0 at once and R=0.
